// File: rtl/seg7_clock_ctrl.sv
// Time-of-day controller: packed-BCD HH:MM:SS, key-driven set mode and blink blanking for the seg7 scan driver.
// Optional alarm compiled in by defining SEG7_CLOCK_ALARM_EN.
module seg7_clock_ctrl #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BLINK_HALF = 12_500_000
`ifdef SEG7_CLOCK_ALARM_EN
    ,
    parameter logic [23:0] ALARM_TIME = 24'h07_00_00
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_mode,
    input  logic        key_inc,
    output logic [23:0] data,
    output logic [5:0]  blank,
    output logic        setting,
    output logic        tick_1hz
`ifdef SEG7_CLOCK_ALARM_EN
    ,
    output logic        alarm
`endif
);

    localparam int unsigned PRESC_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned BLINK_W = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_ph_q, blink_ph_d;
    logic [23:0]          data_d;
    logic [5:0]           blank_d;
    logic                 setting_d;
    logic                 tick_d;
    logic [8:0]           sec_n, min_n, hr_n;

`ifdef SEG7_CLOCK_ALARM_EN
    localparam int unsigned ALM_W = 6;
    logic                 alarm_d;
    logic [ALM_W-1:0]     alarm_cnt_q, alarm_cnt_d;
`endif

    // Increment a two-digit BCD field; bit 8 flags the wrap from max_v back to 00.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [8:0] r;
        if (v == max_v)          r = {1'b1, 8'h00};
        else if (v[3:0] == 4'd9) r = {1'b0, v[7:4] + 4'd1, 4'd0};
        else                     r = {1'b0, v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    assign sec_n = bcd_inc(data[7:0],   8'h59);
    assign min_n = bcd_inc(data[15:8],  8'h59);
    assign hr_n  = bcd_inc(data[23:16], 8'h23);

    // Registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            data        <= 24'h000000;
            blank       <= 6'b000000;
            setting     <= 1'b0;
            tick_1hz    <= 1'b0;
`ifdef SEG7_CLOCK_ALARM_EN
            alarm       <= 1'b0;
            alarm_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            data        <= data_d;
            blank       <= blank_d;
            setting     <= setting_d;
            tick_1hz    <= tick_d;
`ifdef SEG7_CLOCK_ALARM_EN
            alarm       <= alarm_d;
            alarm_cnt_q <= alarm_cnt_d;
`endif
        end
    end

    // Next state, time update, prescaler, blink and output decode
    always_comb begin
        state_d     = state_q;
        data_d      = data;
        presc_d     = presc_q;
        tick_d      = 1'b0;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        blank_d     = 6'b000000;
        setting_d   = 1'b0;
`ifdef SEG7_CLOCK_ALARM_EN
        alarm_d     = alarm;
        alarm_cnt_d = alarm_cnt_q;
`endif

        // key_mode takes priority; a simultaneous key_inc is dropped
        case (state_q)
            ST_RUN: begin
                if (key_mode) state_d = ST_SET_HR;
                if (tick_1hz) begin
                    data_d[7:0] = sec_n[7:0];
                    if (sec_n[8]) begin
                        data_d[15:8] = min_n[7:0];
                        if (min_n[8]) data_d[23:16] = hr_n[7:0];
                    end
                end
            end
            ST_SET_HR: begin
                if (key_mode)     state_d = ST_SET_MIN;
                else if (key_inc) data_d[23:16] = hr_n[7:0];
            end
            ST_SET_MIN: begin
                if (key_mode)     state_d = ST_SET_SEC;
                else if (key_inc) data_d[15:8] = min_n[7:0];
            end
            ST_SET_SEC: begin
                if (key_mode)     state_d = ST_RUN;
                else if (key_inc) data_d[7:0] = sec_n[7:0];
            end
            default: state_d = ST_RUN;
        endcase

        // Prescaler only counts while staying in RUN, so re-entry restarts a full period
        if (state_q == ST_RUN && state_d == ST_RUN) begin
            if (presc_q == PRESC_W'(CLK_HZ - 1)) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end else begin
            presc_d = '0;
        end

        // Any key press restarts the blink in the visible phase
        if (key_mode || key_inc) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end

`ifdef SEG7_CLOCK_ALARM_EN
        if (state_q != ST_RUN || key_mode) begin
            alarm_d = 1'b0;
        end else if (key_inc) begin
            alarm_d = 1'b0;
        end else if (tick_1hz) begin
            if (data_d == ALARM_TIME) begin
                alarm_d     = 1'b1;
                alarm_cnt_d = '0;
            end else if (alarm) begin
                if (alarm_cnt_q == ALM_W'(59)) alarm_d = 1'b0;
                else                           alarm_cnt_d = alarm_cnt_q + ALM_W'(1);
            end
        end
`endif

        case (state_d)
            ST_SET_HR:  blank_d[5:4] = {2{blink_ph_d}};
            ST_SET_MIN: blank_d[3:2] = {2{blink_ph_d}};
            ST_SET_SEC: blank_d[1:0] = {2{blink_ph_d}};
            default:    blank_d      = 6'b000000;
        endcase
`ifdef SEG7_CLOCK_ALARM_EN
        if (alarm_d) blank_d = {6{blink_ph_d}};
`endif

        setting_d = (state_d != ST_RUN);
    end

endmodule

// File: doc/seg7_clock_ctrl.md
Name: seg7_clock_ctrl

Overview:
- Time-of-day controller feeding the 6-digit multiplexed 7-segment scan driver.
- Keeps HH:MM:SS in packed BCD and presents it as a 24-bit display word.
- Runs a key-driven set-mode state machine and generates per-digit blank flags so the field being edited blinks.
- Sits between the debounced key pulses and the seg7 scan driver; `data` connects directly to that driver's data input.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency; the prescaler produces one 1 Hz tick every CLK_HZ cycles.
- BLINK_HALF, 12_500_000, clk cycles per blink half-period (blink rate 2 Hz at default).
- ALARM_TIME, 24'h07_00_00, BCD HHMMSS alarm compare value (used only with ALARM_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_mode  in  1  single-cycle pulse, already debounced; advances the mode
- key_inc  in  1  single-cycle pulse, already debounced; increments the selected field
- data  out  24  BCD display word: [23:20]=H tens, [19:16]=H units, [15:12]=M tens, [11:8]=M units, [7:4]=S tens, [3:0]=S units
- blank  out  6  per-digit blank request; bit5 maps to data[23:20], bit0 maps to data[3:0]
- setting  out  1  high in any SET state
- tick_1hz  out  1  one-cycle pulse when the prescaler wraps
- alarm  out  1  alarm active (present only with ALARM_EN)

Behaviour:
Reset (asynchronous, on rst_n low):
- data=24'h000000, blank=0, setting=0, tick_1hz=0, alarm=0.
- State=RUN; prescaler and blink counters cleared.

Prescaler:
- Counts 0..CLK_HZ-1 and wraps.
- tick_1hz is registered and high for exactly 1 cycle on the wrap.
- The prescaler runs only in RUN and is held at 0 in every SET state.

States:
- RUN, SET_HR, SET_MIN, SET_SEC.
- key_mode transitions: RUN->SET_HR->SET_MIN->SET_SEC->RUN.
- On SET_SEC->RUN the prescaler restarts from 0, so the first tick comes CLK_HZ cycles later.

RUN, on tick_1hz:
- Seconds units 9->0 carries into tens; seconds 59->00 carries into minutes; minutes 59->00 carries into hours.
- Hours 23->00; a full rollover 23:59:59->00:00:00 happens on one tick.
- BCD digits never hold A-F.
- key_inc is ignored in RUN, except to clear the alarm under ALARM_EN.

SET states:
- key_inc increments only the selected field by 1, with no carry into other fields.
- Wrap rules: hours 23->00, minutes 59->00, seconds 59->00.
- Time does not advance in any SET state.

Simultaneous events:
- key_mode and key_inc in the same cycle: key_mode wins and key_inc is dropped.
- Update latency: data updates on the clk edge after the tick or key pulse (1 cycle).

Blink:
- The blink counter runs 0..BLINK_HALF-1 and toggles phase on wrap.
- It is cleared to phase 0 (visible) on every key_mode or key_inc pulse.
- In a SET state during phase 1, the two selected-field bits of blank are 1: SET_HR -> blank[5:4], SET_MIN -> [3:2], SET_SEC -> [1:0].
- All other blank bits are 0; blank=0 in RUN.

Other outputs:
- setting = (state != RUN), registered.
- Reset mid-edit abandons the edit: time returns to 00:00:00 and state to RUN.

Optional Feature:
- Macro: SEG7_CLOCK_ALARM_EN.

Compiled in:
- alarm sets when, in RUN, a tick makes data == ALARM_TIME.
- alarm clears on key_inc in RUN (that pulse causes no other effect), or automatically after 60 ticks.
- alarm is forced to 0 on entering any SET state.
- While alarm=1, blank toggles all six bits with the blink phase.

Compiled out:
- No alarm port and no alarm logic.
- key_inc in RUN has no effect.

Test Plan:
- Reset with CLK_HZ=10 -> data=000000, setting=0, blank=0; first tick_1hz arrives 10 cycles after reset release and data becomes 000001.
- Preload 23:59:59 via SET states, return to RUN, then one tick -> data=000000 in the cycle after the tick.
- Single key_mode then 25 key_inc pulses with hours=00 -> hours=01 (wrap at 24); minutes and seconds unchanged; no ticks occur while in SET.
- In SET_MIN with BLINK_HALF=4, no keys -> blank alternates 6'b000000/6'b001100 every 4 cycles; a key_inc forces 000000 immediately.
- key_mode and key_inc on the same cycle in SET_HR -> state SET_MIN, hours unchanged.
- With SEG7_CLOCK_ALARM_EN and ALARM_TIME=000005 -> alarm rises with the tick producing 000005; key_inc in RUN clears it; if no key, it clears after 60 ticks (at 000105).
